uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

UART serial transmitter; counterpart of the block-based UART receiver in the APB UART datapath. It accepts one `DATA_WIDTH`-bit word and serialises it onto `TX` as back-to-back UART frames of `frame_length` data bits each, LSB first. Each frame has optional parity and one or two stop bits. It runs on the 16x-baud tick, so every bit lasts 16 clock cycles and matches the receiver's sampling.

## Interface
- `DATA_WIDTH`, default 32: width of the word transmitted per request (macro-defined in `Defines.sv`).
- `tx_tick` in 1: clock, 16x baud rate.
- `PRESET` in 1: synchronous, active-high reset.
- `tx_data_in` in `DATA_WIDTH`: word to send; bit 0 goes first.
- `tx_start` in 1: request. Accepted only in IDLE.
- `frame_length` in 4: data bits per frame. Legal values are 5..8; any other value is treated as 8.
- `stop_bit` in 1: 0 selects one stop bit, 1 selects two.
- `parity` in 2: `parity[1]` enables parity. 2'b10 is odd (parity bit = ~^frame bits); 2'b11 is even (parity bit = ^frame bits); 2'b0x disables parity.
- `TX` out 1: serial line. Idles high.
- `tx_busy` out 1: high while a word is in flight.
- `tx_done` out 1: one-cycle pulse when the word completes.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE:
  - Outputs: `TX`=1, `tx_busy`=0.
  - On `tx_start`=1, latch `tx_data_in`, `frame_length` (clamped), `stop_bit` and `parity`, then go to START.
  - Inputs are ignored after acceptance; later changes have no effect until the next IDLE.
- START: `TX`=0 for 16 ticks, then DATA.
- DATA:
  - `TX` = `word[index_cnt]` for 16 ticks per bit; `index_cnt` increments after each bit.
  - When `index_cnt` ≥ `DATA_WIDTH`, pad bits of 0 are driven so the final frame is full length.
  - After `frame_length` bits, go to PARITY if parity is enabled, else STOP1.
- PARITY: drive the parity bit, computed over the `frame_length` bits of the current frame (pads included), for 16 ticks. Then STOP1.
- STOP1:
  - `TX`=1 for 16 ticks.
  - Then STOP2 if `stop_bit`=1.
  - Otherwise, START if `index_cnt` < `DATA_WIDTH`, else DONE.
- STOP2: `TX`=1 for 16 ticks; then START if `index_cnt` < `DATA_WIDTH`, else DONE.
- DONE: `TX`=1, `tx_busy`=0, `tx_done`=1 for one cycle, then IDLE. A `tx_start` in DONE is ignored.
- Frame count = ceil(`DATA_WIDTH` / `frame_length`). For 32 bits: 4 frames at length 8, 5 at 7, 6 at 6, 7 at 5.
- Counters:
  - `tick_cnt`: 4 bits, wraps 15→0 at each bit boundary.
  - `bit_cnt`: 4 bits, counts bits within a frame, cleared at START.
  - `index_cnt`: clog2(`DATA_WIDTH`)+1 bits, cleared on acceptance, saturating (never wraps).
  - Parity accumulator: cleared at START, XOR of each data bit as it is driven.

## Timing
- Reset values: `TX`=1, `tx_busy`=0, `tx_done`=0, state IDLE, all counters 0.
- Reset is sampled every edge, including mid-frame. The frame aborts, `TX`=1 from the next cycle, and no `tx_done` is issued.
- Acceptance occurs at edge k (IDLE, `tx_start`=1). `TX` falls and `tx_busy` rises at the output of edge k+1.
- Each bit occupies exactly 16 consecutive cycles; `TX` changes only on bit boundaries.
- Bits per frame B = 1 + `frame_length` + `parity[1]` + 1 + `stop_bit`. Total bits N = frames × B.
- `tx_done` is high in cycle k+1+16·N, with `tx_busy` already 0. A new request is accepted no earlier than cycle k+2+16·N.
- There is no idle gap between frames of one word: the START of the next frame immediately follows the last stop bit.
- All outputs are registered (glitch-free `TX`).

## Test plan
- Reset with `tx_start` high: no transmission begins while `PRESET` is high; `TX`=1, `tx_busy`=0, `tx_done`=0. Deassert reset with `tx_start` held high: acceptance occurs and `TX` falls 1 cycle later.
- Word 32'hA5C30F81, `frame_length`=8, no parity, one stop:
  - 4 frames of 10 bits, 640 ticks.
  - Frame 0 data bits are 1,0,0,0,0,0,0,1.
  - `tx_done` at k+641.
  - A reference receiver model recovers 32'hA5C30F81.
- Same word with `parity`=2'b11:
  - Parity bit of frame 0 (0x81) is 0; of frame 1 (0x0F) is 0.
  - With `parity`=2'b10 both parity bits are 1.
  - Total 704 ticks.
- `frame_length`=5, `stop_bit`=1, word 32'hFFFFFFFF:
  - 7 frames of 8 bits, 896 ticks.
  - Last frame data is 1,1,0,0,0.
- Change `tx_data_in` and `frame_length` mid-word, and pulse `tx_start` during busy and during DONE: the serial output is unchanged and no extra word is sent.
- Assert `PRESET` during frame 2, data bit 3: `TX`=1 the next cycle, no `tx_done`. A subsequent request transmits correctly from bit 0.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: request/serial-line bundle between a UART transmit client and uart_tx_frame.
`default_nettype none

interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tx_data_in;
  logic                  tx_start;
  logic [3:0]            frame_length;
  logic                  stop_bit;
  logic [1:0]            parity;
  logic                  TX;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_data_in, tx_start, frame_length, stop_bit, parity,
    input  TX, tx_busy, tx_done
  );

  modport slave (
    input  tx_data_in, tx_start, frame_length, stop_bit, parity,
    output TX, tx_busy, tx_done
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one DATA_WIDTH-bit word as back-to-back UART frames, 16 ticks per bit.
// Rev 1.0 - initial release.
`default_nettype none

module uart_tx_frame #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             tx_tick,
  input  logic             PRESET,
  uart_tx_frame_if.slave   bus
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]            state;
  logic [3:0]            tick_cnt;
  logic [3:0]            bit_cnt;
  logic [IDX_W-1:0]      index_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [3:0]            len_m1;
  logic                  two_stop;
  logic [1:0]            par_mode;
  logic                  par_acc;
  logic                  tx_line;
  logic                  busy;
  logic                  done;

  logic [3:0]            len_clamped;
  logic                  bit_end;
  logic                  words_left;

  always_comb begin
    len_clamped = 4'd8;
    if (bus.frame_length >= 4'd5 && bus.frame_length <= 4'd8)
      len_clamped = bus.frame_length;
    bit_end    = (tick_cnt == 4'd15);
    words_left = (index_cnt < IDX_W'(DATA_WIDTH));
  end

  // The FSM runs one cycle ahead of tx_line: each state drives the line on the edges it occupies.
  always_ff @(posedge tx_tick) begin
    if (PRESET) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      index_cnt <= '0;
      shift     <= '0;
      len_m1    <= '0;
      two_stop  <= 1'b0;
      par_mode  <= '0;
      par_acc   <= 1'b0;
      tx_line   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx_line  <= 1'b1;
          busy     <= 1'b0;
          tick_cnt <= '0;
          if (bus.tx_start) begin
            shift     <= bus.tx_data_in;
            len_m1    <= len_clamped - 4'd1;
            two_stop  <= bus.stop_bit;
            par_mode  <= bus.parity;
            index_cnt <= '0;
            state     <= START;
          end
        end
        START: begin
          tx_line  <= 1'b0;
          busy     <= 1'b1;
          bit_cnt  <= '0;
          par_acc  <= 1'b0;
          tick_cnt <= tick_cnt + 4'd1;
          if (bit_end)
            state <= DATA;
        end
        DATA: begin
          // Shifting in zeros supplies the pad bits once the word is exhausted.
          tx_line  <= shift[0];
          busy     <= 1'b1;
          tick_cnt <= tick_cnt + 4'd1;
          if (bit_end) begin
            shift   <= shift >> 1;
            par_acc <= par_acc ^ shift[0];
            bit_cnt <= bit_cnt + 4'd1;
            if (words_left)
              index_cnt <= index_cnt + IDX_W'(1);
            if (bit_cnt == len_m1)
              state <= par_mode[1] ? PARITY : STOP1;
          end
        end
        PARITY: begin
          tx_line  <= par_mode[0] ? par_acc : ~par_acc;
          busy     <= 1'b1;
          tick_cnt <= tick_cnt + 4'd1;
          if (bit_end)
            state <= STOP1;
        end
        STOP1: begin
          tx_line  <= 1'b1;
          busy     <= 1'b1;
          tick_cnt <= tick_cnt + 4'd1;
          if (bit_end) begin
            if (two_stop)
              state <= STOP2;
            else
              state <= words_left ? START : DONE;
          end
        end
        STOP2: begin
          tx_line  <= 1'b1;
          busy     <= 1'b1;
          tick_cnt <= tick_cnt + 4'd1;
          if (bit_end)
            state <= words_left ? START : DONE;
        end
        DONE: begin
          tx_line  <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
          tick_cnt <= '0;
          state    <= IDLE;
        end
        default: begin
          tx_line <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX      = tx_line;
  assign bus.tx_busy = busy;
  assign bus.tx_done = done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table-driven check of uart_tx_frame framing, timing, reset and request handling.
`default_nettype none

module tb_uart_tx_frame;

  localparam int DW = 32;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  fl;
    logic        sb;
    logic [1:0]  par;
    int          ticks;
    int          p0;
    logic        v0;
    int          p1;
    logic        v1;
  } vec_t;

  logic tx_tick = 1'b0;
  logic PRESET;

  uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .tx_tick (tx_tick),
    .PRESET  (PRESET),
    .bus     (bus)
  );

  always #5 tx_tick = ~tx_tick;

  int   tests = 0;
  int   fails = 0;
  logic cap     [0:4095];
  int   cap_n;
  logic exp_bits[0:4095];
  int   exp_n;
  vec_t vecs[7];

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int eff_len(input logic [3:0] fl);
    return (fl >= 4'd5 && fl <= 4'd8) ? int'(fl) : 8;
  endfunction

  task automatic build_model(input vec_t v);
    int   len;
    int   idx;
    logic b;
    logic p;
    len   = eff_len(v.fl);
    idx   = 0;
    exp_n = 0;
    while (idx < DW) begin
      exp_bits[exp_n] = 1'b0; exp_n++;
      p = 1'b0;
      for (int j = 0; j < len; j++) begin
        b = (idx < DW) ? v.data[idx] : 1'b0;
        exp_bits[exp_n] = b; exp_n++;
        p = p ^ b;
        idx++;
      end
      if (v.par[1]) begin
        exp_bits[exp_n] = v.par[0] ? p : ~p; exp_n++;
      end
      exp_bits[exp_n] = 1'b1; exp_n++;
      if (v.sb) begin
        exp_bits[exp_n] = 1'b1; exp_n++;
      end
    end
  endtask

  // Independent receiver: samples mid-bit and reassembles the word from the frames.
  task automatic recover(input vec_t v, output logic [31:0] word, output int errs);
    int nb, pos, idx, len;
    len  = eff_len(v.fl);
    nb   = cap_n / 16;
    pos  = 0;
    idx  = 0;
    word = '0;
    errs = 0;
    while (pos < nb && pos < 250) begin
      if (cap[16*pos+8] !== 1'b0) errs++;
      pos++;
      for (int j = 0; j < len; j++) begin
        if (idx < DW) word[idx] = cap[16*pos+8];
        idx++;
        pos++;
      end
      if (v.par[1]) pos++;
      if (cap[16*pos+8] !== 1'b1) errs++;
      pos++;
      if (v.sb) pos++;
    end
  endtask

  task automatic run_word(input vec_t v, input bit disturb, output int done_c);
    int c;
    int lim;
    @(negedge tx_tick);
    bus.tx_data_in   = v.data;
    bus.frame_length = v.fl;
    bus.stop_bit     = v.sb;
    bus.parity       = v.par;
    bus.tx_start     = 1'b1;
    @(negedge tx_tick);
    bus.tx_start = 1'b0;
    check_bit("tx_high_at_accept", bus.TX, 1'b1);
    c      = 0;
    done_c = -1;
    cap_n  = 0;
    lim    = v.ticks + 64;
    while (c < lim && done_c < 0) begin
      @(negedge tx_tick);
      c++;
      if (bus.tx_done) begin
        done_c = c;
        check_bit("busy_low_at_done", bus.tx_busy, 1'b0);
      end else begin
        cap[cap_n] = bus.TX;
        cap_n++;
      end
      if (c == 1) begin
        check_bit("tx_falls_k1", bus.TX, 1'b0);
        check_bit("busy_rises_k1", bus.tx_busy, 1'b1);
      end
      if (disturb) begin
        if (c == 100) begin
          bus.tx_data_in   = ~bus.tx_data_in;
          bus.frame_length = 4'd5;
        end
        if (c == 200)     bus.tx_start = 1'b1;
        if (c == 201)     bus.tx_start = 1'b0;
        if (c == v.ticks) bus.tx_start = 1'b1;
        if (done_c > 0)   bus.tx_start = 1'b0;
      end
    end
    bus.tx_start = 1'b0;
  endtask

  task automatic eval_word(input vec_t v, input int done_c, input string tag);
    int          errs;
    int          rx_errs;
    logic [31:0] rx_word;
    build_model(v);
    check_int({tag, "_done_cycle"}, done_c, v.ticks + 1);
    check_int({tag, "_tx_cycles"}, cap_n, exp_n * 16);
    errs = 0;
    for (int i = 0; i < exp_n && 16*i+15 < 4096; i++)
      for (int j = 0; j < 16; j++)
        if (cap[16*i+j] !== exp_bits[i]) errs++;
    check_int({tag, "_stream_errs"}, errs, 0);
    recover(v, rx_word, rx_errs);
    check_word({tag, "_rx_word"}, rx_word, v.data);
    check_int({tag, "_rx_frame_errs"}, rx_errs, 0);
    check_bit({tag, "_chk0"}, cap[16*v.p0+8], v.v0);
    check_bit({tag, "_chk1"}, cap[16*v.p1+8], v.v1);
  endtask

  task automatic idle_check(input int cycles, input string tag);
    int busy_n, done_n, low_n;
    busy_n = 0; done_n = 0; low_n = 0;
    repeat (cycles) begin
      @(negedge tx_tick);
      if (bus.tx_busy)  busy_n++;
      if (bus.tx_done)  done_n++;
      if (!bus.TX)      low_n++;
    end
    check_int({tag, "_busy_cycles"}, busy_n, 0);
    check_int({tag, "_done_pulses"}, done_n, 0);
    check_int({tag, "_tx_low_cycles"}, low_n, 0);
  endtask

  initial begin
    int dc;
    int c;

    vecs[0] = '{32'hA5C30F81, 4'd8, 1'b0, 2'b00, 640, 2, 1'b0,  8, 1'b1};
    vecs[1] = '{32'hA5C30F81, 4'd8, 1'b0, 2'b11, 704, 9, 1'b0, 20, 1'b0};
    vecs[2] = '{32'hA5C30F81, 4'd8, 1'b0, 2'b10, 704, 9, 1'b1, 20, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 4'd5, 1'b1, 2'b00, 896, 50, 1'b1, 51, 1'b0};
    vecs[4] = '{32'h12345678, 4'd7, 1'b1, 2'b11, 880, 4, 1'b1,  8, 1'b0};
    vecs[5] = '{32'h00000001, 4'd3, 1'b0, 2'b00, 640, 1, 1'b1,  2, 1'b0};
    vecs[6] = '{32'hDEADBEEF, 4'd6, 1'b0, 2'b10, 864, 5, 1'b0,  7, 1'b0};

    // Reset held with a pending request: nothing may start.
    PRESET           = 1'b1;
    bus.tx_data_in   = vecs[0].data;
    bus.frame_length = 4'd8;
    bus.stop_bit     = 1'b0;
    bus.parity       = 2'b00;
    bus.tx_start     = 1'b1;
    repeat (5) begin
      @(negedge tx_tick);
      check_bit("rst_tx", bus.TX, 1'b1);
      check_bit("rst_busy", bus.tx_busy, 1'b0);
      check_bit("rst_done", bus.tx_done, 1'b0);
    end
    PRESET = 1'b0;
    @(negedge tx_tick);
    check_bit("rel_tx_at_accept", bus.TX, 1'b1);
    @(negedge tx_tick);
    check_bit("rel_tx_falls", bus.TX, 1'b0);
    check_bit("rel_busy", bus.tx_busy, 1'b1);
    bus.tx_start = 1'b0;
    PRESET       = 1'b1;
    repeat (2) @(negedge tx_tick);
    PRESET = 1'b0;
    idle_check(20, "post_rst");

    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i], 1'b0, dc);
      eval_word(vecs[i], dc, $sformatf("vec%0d", i));
      idle_check(8, $sformatf("vec%0d_after", i));
    end

    // Inputs changed and requests pulsed while busy and in DONE.
    run_word(vecs[1], 1'b1, dc);
    eval_word(vecs[1], dc, "disturb");
    idle_check(40, "disturb_after");

    // Abort during frame 2, data bit 3 (bit slot 24).
    @(negedge tx_tick);
    bus.tx_data_in   = vecs[0].data;
    bus.frame_length = 4'd8;
    bus.stop_bit     = 1'b0;
    bus.parity       = 2'b00;
    bus.tx_start     = 1'b1;
    @(negedge tx_tick);
    bus.tx_start = 1'b0;
    c = 0;
    while (c < 390) begin
      @(negedge tx_tick);
      c++;
    end
    check_bit("abort_busy_before", bus.tx_busy, 1'b1);
    PRESET = 1'b1;
    @(negedge tx_tick);
    check_bit("abort_tx", bus.TX, 1'b1);
    check_bit("abort_busy", bus.tx_busy, 1'b0);
    PRESET = 1'b0;
    idle_check(700, "abort_after");
    run_word(vecs[0], 1'b0, dc);
    eval_word(vecs[0], dc, "post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
